// File: rtl/regfile_dump_reader_if.sv
// Beat/handshake bundle for regfile_dump_reader: control, register-file read port and output stream.
// master = dump reader side, slave = register file plus consumer side.
interface regfile_dump_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic                  abort;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;
    logic                  out_csum;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, abort, rf_data, out_ready,
        output rf_addr, out_valid, out_data, out_addr, out_last, out_csum, busy, done
    );

    modport slave (
        output start, abort, rf_data, out_ready,
        input  rf_addr, out_valid, out_data, out_addr, out_last, out_csum, busy, done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks every register-file entry and streams it out as valid/ready beats.
// Define REGDUMP_CHECKSUM_EN to append a trailing XOR-checksum beat.
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_dump_reader_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  handshake;
    logic                  at_last;
    logic                  abort_live;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  out_csum_q, out_csum_d;
`endif

    assign handshake  = out_valid_q & bus.out_ready;
    assign at_last    = (index_q == LAST_IDX);
    assign abort_live = bus.abort && (state_q != IDLE) && (state_q != DONE);

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d       = acc_q;
        out_csum_d  = out_csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    index_d = '0;
                    state_d = READ;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            READ: begin
                out_data_d  = bus.rf_data;
                out_addr_d  = index_q;
                out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
                out_csum_d  = 1'b0;
`else
                out_last_d  = at_last;
`endif
                state_d     = SEND;
            end
            SEND: begin
                if (handshake) begin
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d = acc_q ^ out_data_q;
`endif
                    if (!at_last) begin
                        index_d     = index_q + IDX_ONE;
                        out_valid_d = 1'b0;
                        state_d     = READ;
                    end else begin
`ifdef REGDUMP_CHECKSUM_EN
                        // Fold the final word in directly so the checksum beat follows without a gap.
                        out_data_d = acc_q ^ out_data_q;
                        out_addr_d = '0;
                        out_last_d = 1'b1;
                        out_csum_d = 1'b1;
                        state_d    = CSUM;
`else
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = DONE;
`endif
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_csum_d  = 1'b0;
                    state_d     = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (abort_live) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            out_csum_d  = 1'b0;
`endif
        end
    end

    assign busy_d = (state_d != IDLE);
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q       <= '0;
            out_csum_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q       <= acc_d;
            out_csum_q  <= out_csum_d;
`endif
        end
    end

    assign bus.rf_addr   = index_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef REGDUMP_CHECKSUM_EN
    assign bus.out_csum  = out_csum_q;
`else
    assign bus.out_csum  = 1'b0;
`endif
endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the register index width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a full dump.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a dump in progress.
REQ-007 SHALL have port rf_addr  output  ADDR_WIDTH  read address to the register file read port.
REQ-008 SHALL have port rf_data  input  DATA_WIDTH  combinational read data returned for rf_addr.
REQ-009 SHALL have port out_valid  output  1  out_* beat is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  register contents or checksum.
REQ-012 SHALL have port out_addr  output  ADDR_WIDTH  register index of the beat; 0 on a checksum beat.
REQ-013 SHALL have port out_last  output  1  final beat of the dump.
REQ-014 SHALL have port out_csum  output  1  beat carries the checksum.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 SHALL implement FSM states IDLE, READ, SEND, CSUM, DONE.
REQ-018 IDLE: start=1 -> index cleared to 0, go to READ; otherwise remain.
REQ-019 rf_addr SHALL equal the internal index register in all states.
REQ-020 READ: rf_data captured into out_data, index into out_addr, out_valid set, go to SEND.
REQ-021 SEND: out_valid held; out_data/out_addr/out_last SHALL NOT change until out_valid&out_ready.
REQ-022 SEND handshake with index<DEPTH-1: index+1, out_valid cleared, go to READ.
REQ-023 SEND handshake with index=DEPTH-1: go to CSUM if checksum is compiled in, else DONE.
REQ-024 out_last SHALL be 1 on the index=DEPTH-1 beat only when checksum is compiled out.
REQ-025 DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
REQ-026 Latency: start in cycle N -> out_valid first high in cycle N+2; each word takes 2 cycles with out_ready held high.
REQ-027 start while busy SHALL be ignored; no restart, no queued request.
REQ-028 abort in READ, SEND, or CSUM SHALL force IDLE on the next edge with out_valid=0, no done pulse; abort beats any same-cycle handshake.
REQ-029 abort in IDLE or DONE SHALL have no effect; done still pulses in DONE.
REQ-030 Index arithmetic SHALL be ADDR_WIDTH wide; it never wraps during a dump because increment stops at DEPTH-1.

Reset
REQ-031 rst low SHALL immediately force IDLE, index=0, rf_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, out_csum=0, busy=0, done=0, checksum accumulator=0.
REQ-032 rst asserted mid-dump SHALL discard the dump; no beat or done pulse follows reset release.

Configuration
REQ-033 Macro REGDUMP_CHECKSUM_EN SHALL select checksum support.
REQ-034 Defined: accumulator cleared on start and XORed with each accepted register word; CSUM presents one beat with out_data=accumulator, out_addr=0, out_csum=1, out_last=1, held until handshake, then DONE.
REQ-035 Undefined: no accumulator or CSUM state; out_csum tied 0; dump is DEPTH beats.

Verification
REQ-036 Register file preloaded with reg[i]=i*0x11111111 and out_ready=1; pulse start -> 32 beats, addr 0..31 in order with matching data, out_last on addr 31 (no EN), done one cycle after last handshake, 65 cycles start-to-done.
REQ-037 With REGDUMP_CHECKSUM_EN and reg[i]=i: 33 beats; the 33rd has out_data=0x00000000, out_csum=1, out_last=1.
REQ-038 out_ready low for 5 cycles on beat addr 7 -> out_valid, out_data, and out_addr stable for all 5 cycles; addr 8 follows only after acceptance.
REQ-039 Pulse start again at beat 10 -> ignored; the dump completes normally with exactly 32 (or 33) beats and one done.
REQ-040 Assert abort during SEND at addr 12 -> out_valid=0 and busy=0 next cycle, no done; a new start restarts at addr 0.
REQ-041 Pull rst low mid-beat at addr 20 -> all outputs 0 immediately; no beats after release until start.
